// File: rtl/ddr3_burst_adapter.sv
// Line-read buffer: registered pointers, head line visible combinationally; push and pop may coincide.
// Latency: a pushed line is at the head the following cycle; pushes while full are dropped.
module sync_fifo #(
   parameter int W     = 128,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_vld,
   input  logic [W-1:0]             push_dat,
   input  logic                     pop_rdy,
   output logic [W-1:0]             head_dat,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_pop   = pop_rdy && (count != '0);
   assign do_push  = push_vld && ((count != (AW+1)'(DEPTH)) || do_pop);
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end
endmodule

// 32-bit memory port to 128-bit DDR3 line adapter: masked line writes, credit-limited pipelined line reads.
// Read words stream at up to 1/clk, first word 2 clk after the first line returns; ddr_cmd_valid holds until ready.
module ddr3_burst_adapter #(
   parameter int ADDR_W    = 25,
   parameter int RDQ_DEPTH = 4,
   parameter int MAX_BURST = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_din,
   input  logic [3:0]        mem_be,
   input  logic [7:0]        mem_burstcount,
   input  logic              mem_rd,
   input  logic              mem_we,
   output logic              mem_busy,
   output logic [31:0]       mem_dout,
   output logic              mem_dout_ready,
   output logic              ddr_cmd_valid,
   input  logic              ddr_cmd_ready,
   output logic              ddr_cmd_we,
   output logic [ADDR_W-1:0] ddr_addr,
   output logic [127:0]      ddr_wdata,
   output logic [15:0]       ddr_wmask,
   input  logic [127:0]      ddr_rdata,
   input  logic              ddr_rdata_valid
);
   localparam int CW = $clog2(RDQ_DEPTH) + 1;

   typedef enum logic [1:0] {IDLE, WR_CMD, RD_RUN} state_t;

   state_t            state_q, state_d;
   logic [7:0]        words_left_q, words_left_d;
   logic [7:0]        lines_left_q, lines_left_d;
   logic [1:0]        lane_q, lane_d;
   logic [CW-1:0]     out_cnt_q, out_cnt_d;
   logic [CW-1:0]     buf_cnt, buf_cnt_nxt;
   logic [127:0]      head_line;
   logic              busy_d, dout_rdy_d, cmd_vld_d, cmd_we_d;
   logic [31:0]       dout_d;
   logic [ADDR_W-1:0] addr_d;
   logic [127:0]      wdata_d;
   logic [15:0]       wmask_d;
   logic              cmd_hs, push, emit, pop, can_issue;
   logic [CW:0]       credit_used;
   logic [7:0]        n_words, lane_span;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{mem_addr[31:ADDR_W+4], mem_addr[1:0]};

   sync_fifo #(.W(128), .DEPTH(RDQ_DEPTH)) u_rdq (
      .clk      (clk),
      .reset    (reset),
      .push_vld (push),
      .push_dat (ddr_rdata),
      .pop_rdy  (pop),
      .head_dat (head_line),
      .count    (buf_cnt)
   );

   assign cmd_hs = ddr_cmd_valid && ddr_cmd_ready;
   // Lines arriving outside a read have no owner and are dropped.
   assign push   = ddr_rdata_valid && (state_q == RD_RUN);
   assign emit   = (state_q == RD_RUN) && (buf_cnt != '0) && (words_left_q != 8'd0);
   assign pop    = emit && ((lane_q == 2'd3) || (words_left_q == 8'd1));

   // Credits count accepted-but-unreturned lines plus buffered lines, looking one cycle ahead.
   assign out_cnt_d   = out_cnt_q + CW'(cmd_hs && (state_q == RD_RUN)) - CW'(push);
   assign buf_cnt_nxt = buf_cnt + CW'(push) - CW'(pop);
   assign credit_used = {1'b0, out_cnt_d} + {1'b0, buf_cnt_nxt};
   assign can_issue   = (lines_left_q != 8'd0) && (credit_used < (CW+1)'(RDQ_DEPTH));

   always_comb begin
      n_words = mem_burstcount;
      if (mem_burstcount == 8'd0)                n_words = 8'd1;
      else if (mem_burstcount > 8'(MAX_BURST))   n_words = 8'(MAX_BURST);
      lane_span = 8'(mem_addr[3:2]) + n_words - 8'd1;
   end

   always_comb begin
      state_d      = state_q;
      words_left_d = words_left_q;
      lines_left_d = lines_left_q;
      lane_d       = lane_q;
      busy_d       = mem_busy;
      dout_rdy_d   = 1'b0;
      dout_d       = mem_dout;
      cmd_vld_d    = ddr_cmd_valid;
      cmd_we_d     = ddr_cmd_we;
      addr_d       = ddr_addr;
      wdata_d      = ddr_wdata;
      wmask_d      = ddr_wmask;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (!mem_busy && mem_rd) begin
               state_d      = RD_RUN;
               busy_d       = 1'b1;
               cmd_vld_d    = 1'b1;
               cmd_we_d     = 1'b0;
               addr_d       = mem_addr[ADDR_W+3:4];
               lines_left_d = lane_span >> 2;
               words_left_d = n_words;
               lane_d       = mem_addr[3:2];
            end else if (!mem_busy && mem_we) begin
               state_d   = WR_CMD;
               busy_d    = 1'b1;
               cmd_vld_d = 1'b1;
               cmd_we_d  = 1'b1;
               addr_d    = mem_addr[ADDR_W+3:4];
               wdata_d   = {4{mem_din}};
               wmask_d   = 16'(mem_be) << {mem_addr[3:2], 2'b00};
            end
         end
         WR_CMD: begin
            if (cmd_hs) begin
               state_d   = IDLE;
               cmd_vld_d = 1'b0;
               busy_d    = 1'b0;
            end
         end
         RD_RUN: begin
            if (cmd_hs || !ddr_cmd_valid) begin
               cmd_vld_d = can_issue;
               if (can_issue) begin
                  addr_d       = ddr_addr + 1'b1;
                  lines_left_d = lines_left_q - 8'd1;
               end
            end
            if (emit) begin
               dout_rdy_d   = 1'b1;
               dout_d       = head_line[32*lane_q +: 32];
               words_left_d = words_left_q - 8'd1;
               lane_d       = lane_q + 2'd1;
               // Last word: IDLE drops busy on the following edge.
               if (words_left_q == 8'd1) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         words_left_q   <= '0;
         lines_left_q   <= '0;
         lane_q         <= '0;
         out_cnt_q      <= '0;
         mem_busy       <= 1'b0;
         mem_dout       <= '0;
         mem_dout_ready <= 1'b0;
         ddr_cmd_valid  <= 1'b0;
         ddr_cmd_we     <= 1'b0;
         ddr_addr       <= '0;
         ddr_wdata      <= '0;
         ddr_wmask      <= '0;
      end else begin
         state_q        <= state_d;
         words_left_q   <= words_left_d;
         lines_left_q   <= lines_left_d;
         lane_q         <= lane_d;
         out_cnt_q      <= out_cnt_d;
         mem_busy       <= busy_d;
         mem_dout       <= dout_d;
         mem_dout_ready <= dout_rdy_d;
         ddr_cmd_valid  <= cmd_vld_d;
         ddr_cmd_we     <= cmd_we_d;
         ddr_addr       <= addr_d;
         ddr_wdata      <= wdata_d;
         ddr_wmask      <= wmask_d;
      end
   end
endmodule

// File: tb/tb_ddr3_burst_adapter.sv
// Scoreboarded bench for ddr3_burst_adapter with a queue-based DDR controller model.
module tb_ddr3_burst_adapter;
   localparam int ADDR_W    = 25;
   localparam int RDQ_DEPTH = 4;
   localparam int MAX_BURST = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic [31:0]       mem_addr, mem_din, mem_dout;
   logic [3:0]        mem_be;
   logic [7:0]        mem_burstcount;
   logic              mem_rd, mem_we, mem_busy, mem_dout_ready;
   logic              ddr_cmd_valid, ddr_cmd_ready, ddr_cmd_we, ddr_rdata_valid;
   logic [ADDR_W-1:0] ddr_addr;
   logic [127:0]      ddr_wdata, ddr_rdata;
   logic [15:0]       ddr_wmask;

   always #5 clk = ~clk;

   ddr3_burst_adapter #(.ADDR_W(ADDR_W), .RDQ_DEPTH(RDQ_DEPTH), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be),
      .mem_burstcount(mem_burstcount), .mem_rd(mem_rd), .mem_we(mem_we), .mem_busy(mem_busy),
      .mem_dout(mem_dout), .mem_dout_ready(mem_dout_ready), .ddr_cmd_valid(ddr_cmd_valid),
      .ddr_cmd_ready(ddr_cmd_ready), .ddr_cmd_we(ddr_cmd_we), .ddr_addr(ddr_addr),
      .ddr_wdata(ddr_wdata), .ddr_wmask(ddr_wmask), .ddr_rdata(ddr_rdata),
      .ddr_rdata_valid(ddr_rdata_valid)
   );

   typedef struct {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [127:0]      wdata;
      logic [15:0]       wmask;
   } cmd_t;
   typedef struct {
      logic [ADDR_W-1:0] addr;
      int                due;
   } pend_t;

   cmd_t        exp_cmd[$];
   logic [31:0] exp_word[$];
   pend_t       pend[$];
   int          rd_cmd_cyc[$];
   int checks = 0, failures = 0, cyc = 0;
   int rdy_lo = 0, rdy_hi = 0, rd_lat = 1;
   int tb_out = 0, tb_max_out = 0, first_rv_cyc = -1, words_seen = 0;
   bit stray_req = 0, chk_busy_low = 0;
   cmd_t mon_e;

   function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] line, input int lane);
      return (32'(line) * 32'h0100_0193) ^ (32'(lane) * 32'h2545_F491) ^ 32'h00C0_FFEE;
   endfunction

   function automatic logic [127:0] line_of(input logic [ADDR_W-1:0] line);
      return {word_of(line, 3), word_of(line, 2), word_of(line, 1), word_of(line, 0)};
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // DDR controller model: randomized ready, in-order line returns after rd_lat cycles.
   initial begin
      int wait_cnt = 0;
      int dly = 0;
      pend_t p;
      ddr_cmd_ready = 1'b0; ddr_rdata_valid = 1'b0; ddr_rdata = '0;
      forever begin
         @(posedge clk);
         cyc++;
         if (reset) begin
            pend.delete(); tb_out = 0; wait_cnt = 0;
            #1;
            ddr_cmd_ready = 1'b0; ddr_rdata_valid = 1'b0;
            continue;
         end
         if (ddr_cmd_valid && ddr_cmd_ready) begin
            wait_cnt = 0;
            if (!ddr_cmd_we) begin
               p.addr = ddr_addr; p.due = cyc + rd_lat;
               pend.push_back(p);
               tb_out++;
               if (tb_out > tb_max_out) tb_max_out = tb_out;
               rd_cmd_cyc.push_back(cyc);
            end
         end
         #1;
         if (ddr_cmd_valid) begin
            if (wait_cnt == 0) dly = $urandom_range(rdy_hi, rdy_lo);
            ddr_cmd_ready = (wait_cnt >= dly);
            wait_cnt++;
         end else begin
            ddr_cmd_ready = 1'b0;
            wait_cnt = 0;
         end
         ddr_rdata_valid = 1'b0;
         if (stray_req) begin
            stray_req = 0;
            ddr_rdata_valid = 1'b1;
            ddr_rdata = {4{32'hDEAD_BEEF}};
         end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            ddr_rdata_valid = 1'b1;
            ddr_rdata = line_of(pend[0].addr);
            void'(pend.pop_front());
            tb_out--;
            if (first_rv_cyc < 0) first_rv_cyc = cyc;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a command or a word.
   always @(negedge clk) begin
      if (reset) begin
         chk_busy_low = 0;
      end else begin
         if (chk_busy_low) begin
            check("busy_after_done", mem_busy, 0);
            chk_busy_low = 0;
         end
         if (ddr_cmd_valid && ddr_cmd_ready) begin
            if (exp_cmd.size() == 0) fail_now("unexpected_cmd");
            else begin
               mon_e = exp_cmd.pop_front();
               check("cmd_we", ddr_cmd_we, mon_e.we);
               check("cmd_addr", ddr_addr, mon_e.addr);
               if (mon_e.we) begin
                  check("cmd_wdata", ddr_wdata, mon_e.wdata);
                  check("cmd_wmask", ddr_wmask, mon_e.wmask);
                  chk_busy_low = 1;
               end else begin
                  check("credit_limit", 256'(tb_out < RDQ_DEPTH), 1);
               end
            end
         end
         if (mem_dout_ready) begin
            if (exp_word.size() == 0) fail_now("unexpected_word");
            else begin
               check("dout", mem_dout, exp_word.pop_front());
               words_seen++;
               if (exp_word.size() == 0) chk_busy_low = 1;
            end
         end
      end
   end

   task automatic wait_idle(input int budget);
      int n = 0;
      @(negedge clk);
      while (mem_busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (mem_busy) fail_now("timeout_wait_idle");
   endtask

   task automatic issue_write(input logic [31:0] addr, input logic [31:0] din, input logic [3:0] be);
      cmd_t c;
      int lane;
      wait_idle(4000);
      lane = int'(addr[3:2]);
      c.we = 1'b1; c.addr = addr[ADDR_W+3:4]; c.wdata = {4{din}}; c.wmask = '0;
      for (int b = 0; b < 4; b++) if (be[b]) c.wmask[lane*4+b] = 1'b1;
      exp_cmd.push_back(c);
      mem_addr = addr; mem_din = din; mem_be = be; mem_burstcount = 8'($urandom); mem_we = 1'b1;
      @(posedge clk); #1 mem_we = 1'b0;
   endtask

   task automatic issue_read(input logic [31:0] addr, input logic [7:0] bc, input bit also_we);
      cmd_t c;
      int n;
      logic [31:0] w;
      logic [ADDR_W-1:0] ln, last_ln;
      bit first = 1;
      wait_idle(4000);
      n = (bc == 0) ? 1 : ((bc > MAX_BURST) ? MAX_BURST : int'(bc));
      for (int i = 0; i < n; i++) begin
         w  = (addr >> 2) + 32'(i);
         ln = ADDR_W'(w >> 2);
         exp_word.push_back(word_of(ln, int'(w[1:0])));
         if (first || ln != last_ln) begin
            c.we = 1'b0; c.addr = ln; c.wdata = '0; c.wmask = '0;
            exp_cmd.push_back(c);
            last_ln = ln;
            first = 0;
         end
      end
      mem_addr = addr; mem_burstcount = bc; mem_rd = 1'b1; mem_we = also_we;
      @(posedge clk); #1 mem_rd = 1'b0; mem_we = 1'b0;
   endtask

   task automatic check_drained();
      check("drain", {exp_cmd.size(), exp_word.size()}, 0);
   endtask

   task automatic check_reset_outputs();
      check("reset_outputs", {mem_busy, mem_dout, mem_dout_ready, ddr_cmd_valid, ddr_cmd_we,
                              ddr_addr, ddr_wdata, ddr_wmask}, 0);
   endtask

   initial begin
      int base;
      int n;
      reset = 1'b1; mem_addr = '0; mem_din = '0; mem_be = '0; mem_burstcount = '0;
      mem_rd = 1'b0; mem_we = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      reset = 1'b0;

      rdy_lo = 3; rdy_hi = 3;
      issue_write(32'h104, 32'hAABBCCDD, 4'b0011);
      wait_idle(200); check_drained();

      rdy_lo = 0; rdy_hi = 0; rd_lat = 2;
      issue_write(32'h20C, 32'h1234_5678, 4'b0000);
      issue_read(32'h208, 8'd1, 0);
      wait_idle(200); check_drained();

      issue_read(32'h1008, 8'd8, 0);
      wait_idle(200); check_drained();

      rd_lat = 20; tb_max_out = 0;
      issue_read(32'h2000, 8'd16, 0);
      wait_idle(400); check_drained();
      check("max_outstanding", tb_max_out, RDQ_DEPTH);

      rd_cmd_cyc.delete(); first_rv_cyc = -1;
      issue_read(32'h3004, 8'd16, 0);
      wait_idle(400); check_drained();
      check("fifth_cmd_after_data", 256'((rd_cmd_cyc.size() == 5) && (rd_cmd_cyc[4] > first_rv_cyc)), 1);

      rd_lat = 1;
      issue_read(32'h1FFF_FFF0, 8'd8, 0);
      wait_idle(200); check_drained();

      issue_read(32'h0000_7004, 8'd0, 1);
      wait_idle(200); check_drained();
      issue_read(32'h0000_900C, 8'd40, 0);
      wait_idle(400); check_drained();

      wait_idle(200);
      stray_req = 1;
      repeat (3) @(negedge clk);
      issue_read(32'h500C, 8'd5, 0);
      wait_idle(200); check_drained();

      rd_lat = 3;
      issue_read(32'h4000, 8'd8, 0);
      base = words_seen; n = 0;
      while (words_seen < base + 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (words_seen < base + 2) fail_now("timeout_second_word");
      @(posedge clk); #1 reset = 1'b1;
      exp_cmd.delete(); exp_word.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      reset = 1'b0;
      issue_read(32'h4444, 8'd1, 0);
      wait_idle(200); check_drained();

      for (int t = 0; t < 60; t++) begin
         rdy_lo = 0; rdy_hi = $urandom_range(3, 0); rd_lat = $urandom_range(8, 1);
         if ($urandom_range(1, 0) == 1) issue_write($urandom, $urandom, 4'($urandom));
         else issue_read($urandom, 8'($urandom_range(20, 0)), 0);
         wait_idle(400);
      end
      repeat (2) @(negedge clk);
      check_drained();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
endmodule
